// File: rtl/vector_mem_stage.sv
// Vector memory stage: retires scalar and vector ALU results and sequences
// unit-stride VLE32/VSE32 transfers one SEW-wide beat per memory handshake.
module vector_mem_stage #(
    parameter int VL  = 8,
    parameter int SEW = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_sel,
    input  logic              i_data_access,
    input  logic              i_reg_write,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_vd,
    input  logic [31:0]       i_rs1_data,
    input  logic [31:0]       i_result_s,
    input  logic [VL*SEW-1:0] i_result_v,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_addr,
    output logic [SEW-1:0]    o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [SEW-1:0]    i_mem_rdata,
    output logic              o_wb_s_we,
    output logic [4:0]        o_wb_rd,
    output logic [31:0]       o_wb_s_data,
    output logic              o_wb_v_we,
    output logic [4:0]        o_wb_vd,
    output logic [VL*SEW-1:0] o_wb_v_data,
    output logic              o_misalign
);

    localparam int             BW        = (VL > 1) ? $clog2(VL) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(VL - 1);

    localparam logic [3:0] OP_ADDI  = 4'd0;
    localparam logic [3:0] OP_VLE32 = 4'd1;
    localparam logic [3:0] OP_VSE32 = 4'd2;
    localparam logic [3:0] OP_VADD  = 4'd3;

    typedef enum logic {ST_IDLE, ST_XFER} state_t;
    typedef logic [VL-1:0][SEW-1:0] vec_t;

    state_t        r_state;
    logic [BW-1:0] r_beat;
    logic          r_is_store;
    logic [4:0]    r_vd;
    logic [31:0]   r_base;
    vec_t          r_sdata;
    vec_t          r_ldbuf;

    logic          r_wb_s_we;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_wb_s_data;
    logic          r_wb_v_we;
    logic [4:0]    r_wb_vd;
    vec_t          r_wb_v_data;
    logic          r_misalign;

    logic          w_vec_mem;
    logic          w_misaligned;
    logic          w_last;
    vec_t          w_ld_next;

    assign w_vec_mem    = ((i_sel == OP_VLE32) || (i_sel == OP_VSE32)) && i_data_access;
    assign w_misaligned = (i_rs1_data[1:0] != 2'b00);
    assign w_last       = (r_beat == LAST_BEAT);

    // Memory-side outputs and stall, decoded from the held transfer state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_stall     = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        w_ld_next   = r_ldbuf;
        case (r_state)
            ST_IDLE: begin
                o_stall = w_vec_mem && !w_misaligned;
            end
            ST_XFER: begin
                o_mem_req         = 1'b1;
                o_mem_we          = r_is_store;
                o_mem_addr        = r_base + 32'({r_beat, 2'b00});
                o_mem_wdata       = r_sdata[r_beat];
                w_ld_next[r_beat] = i_mem_rdata;
                o_stall           = !(i_mem_ready && w_last);
            end
            default: ;
        endcase
        if (i_rst) begin
            o_stall = 1'b0;
        end
    end

    // State, beat counter, operand latches and registered writeback/error outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: only control and visible outputs are reset; operand latches and the load buffer are always written before use.
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_wb_s_we   <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_s_data <= '0;
            r_wb_v_we   <= 1'b0;
            r_wb_vd     <= '0;
            r_wb_v_data <= '0;
            r_misalign  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_wb_s_we  <= 1'b0;
            r_wb_v_we  <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_vec_mem) begin
                        if (w_misaligned) begin
                            r_misalign <= 1'b1;
                        end else begin
                            r_is_store <= (i_sel == OP_VSE32);
                            r_vd       <= i_vd;
                            r_base     <= i_rs1_data;
                            r_sdata    <= i_result_v;
                            r_beat     <= '0;
                            r_state    <= ST_XFER;
                        end
                    end else if ((i_sel == OP_ADDI) && i_reg_write) begin
                        r_wb_s_we   <= 1'b1;
                        r_wb_rd     <= i_rd;
                        r_wb_s_data <= i_result_s;
                    end else if ((i_sel == OP_VADD) && i_reg_write) begin
                        r_wb_v_we   <= 1'b1;
                        r_wb_vd     <= i_vd;
                        r_wb_v_data <= i_result_v;
                    end
                end
                ST_XFER: begin
                    if (i_mem_ready) begin
                        if (!r_is_store) begin
                            r_ldbuf <= w_ld_next;
                        end
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_beat  <= '0;
                            if (!r_is_store) begin
                                r_wb_v_we   <= 1'b1;
                                r_wb_vd     <= r_vd;
                                r_wb_v_data <= w_ld_next;
                            end
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_wb_s_we   = r_wb_s_we;
    assign o_wb_rd     = r_wb_rd;
    assign o_wb_s_data = r_wb_s_data;
    assign o_wb_v_we   = r_wb_v_we;
    assign o_wb_vd     = r_wb_vd;
    assign o_wb_v_data = r_wb_v_data;
    assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_vector_mem_stage.sv
// Bench for vector_mem_stage: instruction-level reference model feeds an
// event scoreboard; a negedge monitor compares observed beats and writebacks.
module tb_vector_mem_stage;

    localparam int VL  = 8;
    localparam int SEW = 32;
    localparam int VW  = VL * SEW;

    logic          clk;
    logic          rst;
    logic [3:0]    sel;
    logic          data_access;
    logic          reg_write;
    logic [4:0]    rd;
    logic [4:0]    vd;
    logic [31:0]   rs1_data;
    logic [31:0]   result_s;
    logic [VW-1:0] result_v;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [SEW-1:0] mem_wdata;
    logic          mem_ready;
    logic [SEW-1:0] mem_rdata;
    logic          wb_s_we;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_s_data;
    logic          wb_v_we;
    logic [4:0]    wb_vd;
    logic [VW-1:0] wb_v_data;
    logic          misalign;

    vector_mem_stage #(.VL(VL), .SEW(SEW)) dut (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_data_access(data_access),
        .i_reg_write(reg_write), .i_rd(rd), .i_vd(vd), .i_rs1_data(rs1_data),
        .i_result_s(result_s), .i_result_v(result_v), .o_stall(stall),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_wb_s_we(wb_s_we), .o_wb_rd(wb_rd), .o_wb_s_data(wb_s_data),
        .o_wb_v_we(wb_v_we), .o_wb_vd(wb_vd), .o_wb_v_data(wb_v_data),
        .o_misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {EV_BEAT, EV_SWB, EV_VWB, EV_MIS} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [31:0]   addr;
        logic          we;
        logic [31:0]   data;
        logic [4:0]    idx;
        logic [VW-1:0] vdata;
    } ev_t;

    ev_t         sb[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem_dut [logic [31:0]];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_mode = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic ev_t make_ev(input ev_kind_t k, input logic [31:0] a, input logic w,
                                    input logic [31:0] d, input logic [4:0] ix,
                                    input logic [VW-1:0] vdat);
        ev_t e;
        e.kind = k; e.addr = a; e.we = w; e.data = d; e.idx = ix; e.vdata = vdat;
        return e;
    endfunction

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: one instruction in, the list of visible events out.
    task automatic model(input logic [3:0] s, input logic da, input logic rw,
                         input logic [4:0] rd_i, input logic [4:0] vd_i,
                         input logic [31:0] rs1, input logic [31:0] rs, input logic [VW-1:0] rv);
        logic [VW-1:0] acc;
        logic [31:0]   a;
        logic [31:0]   w;
        acc = '0;
        if ((s == 4'd1 || s == 4'd2) && da) begin
            if (rs1 % 4 != 0) begin
                sb.push_back(make_ev(EV_MIS, 0, 0, 0, 0, '0));
            end else begin
                for (int i = 0; i < VL; i++) begin
                    a = rs1 + 32'(4 * i);
                    if (s == 4'd2) begin
                        w = rv[i*SEW +: SEW];
                        sb.push_back(make_ev(EV_BEAT, a, 1'b1, w, 0, '0));
                        ref_mem[a] = w;
                    end else begin
                        w = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                        sb.push_back(make_ev(EV_BEAT, a, 1'b0, 0, 0, '0));
                        acc[i*SEW +: SEW] = w;
                    end
                end
                if (s == 4'd1) sb.push_back(make_ev(EV_VWB, 0, 0, 0, vd_i, acc));
            end
        end else if (s == 4'd0 && rw) begin
            sb.push_back(make_ev(EV_SWB, 0, 0, rs, rd_i, '0));
        end else if (s == 4'd3 && rw) begin
            sb.push_back(make_ev(EV_VWB, 0, 0, 0, vd_i, rv));
        end
    endtask

    task automatic observe(input ev_t got);
        ev_t exp;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %h expected none", got.kind, got.addr);
            return;
        end
        exp = sb.pop_front();
        check("event_kind", VW'(int'(got.kind)), VW'(int'(exp.kind)));
        if (got.kind != exp.kind) return;
        case (exp.kind)
            EV_BEAT: begin
                check("beat_addr", VW'(got.addr), VW'(exp.addr));
                check("beat_we", VW'(got.we), VW'(exp.we));
                if (exp.we) check("beat_wdata", VW'(got.data), VW'(exp.data));
            end
            EV_SWB: begin
                check("wb_rd", VW'(got.idx), VW'(exp.idx));
                check("wb_s_data", VW'(got.data), VW'(exp.data));
            end
            EV_VWB: begin
                check("wb_vd", VW'(got.idx), VW'(exp.idx));
                check("wb_v_data", got.vdata, exp.vdata);
            end
            default: ;
        endcase
    endtask

    // Memory responder: ready pattern and read data set just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = !mem_ready;
            default: mem_ready = 1'($urandom_range(0, 1));
        endcase
        mem_rdata = mem_dut.exists(mem_addr) ? mem_dut[mem_addr] : init_word(mem_addr);
    end

    // Monitor: values seen at the falling edge are what the next rising edge acts on.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr;
    logic        prev_we;
    logic [31:0] prev_wdata;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold && mem_req) begin
                check("hold_addr", VW'(mem_addr), VW'(prev_addr));
                check("hold_we", VW'(mem_we), VW'(prev_we));
                check("hold_wdata", VW'(mem_wdata), VW'(prev_wdata));
            end
            if (mem_req && mem_ready) begin
                observe(make_ev(EV_BEAT, mem_addr, mem_we, mem_wdata, 0, '0));
                if (mem_we) mem_dut[mem_addr] = mem_wdata;
            end
            if (wb_s_we)  observe(make_ev(EV_SWB, 0, 0, wb_s_data, wb_rd, '0));
            if (wb_v_we)  observe(make_ev(EV_VWB, 0, 0, 0, wb_vd, wb_v_data));
            if (misalign) observe(make_ev(EV_MIS, 0, 0, 0, 0, '0));
        end
        prev_hold  = mem_req && !mem_ready && !rst;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
    end

    task automatic set_bubble();
        sel = 4'd15; data_access = 1'b0; reg_write = 1'b0;
    endtask

    // Present one instruction (called just after a rising edge) until it retires.
    task automatic issue(input logic [3:0] s, input logic da, input logic rw,
                         input logic [4:0] rd_i, input logic [4:0] vd_i,
                         input logic [31:0] rs1, input logic [31:0] rs,
                         input logic [VW-1:0] rv, output int stalls);
        logic st;
        int   cycles;
        logic done;
        sel = s; data_access = da; reg_write = rw; rd = rd_i; vd = vd_i;
        rs1_data = rs1; result_s = rs; result_v = rv;
        model(s, da, rw, rd_i, vd_i, rs1, rs, rv);
        stalls = 0; cycles = 0; done = 1'b0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            st = stall;
            if (st) stalls++;
            @(posedge clk);
            #1;
            cycles++;
            if (!st) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got stall after %0d cycles expected release", cycles);
        end
        set_bubble();
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VL; i++) v[i*SEW +: SEW] = $urandom;
        return v;
    endfunction

    logic [VW-1:0] vpat;
    int            nst;
    logic [3:0]    ops [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15, 4'd6};

    initial begin
        // Reset with an aligned load presented: nothing may start, stall stays low.
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = '0;
        sel = 4'd1; data_access = 1'b1; reg_write = 1'b1; rd = 5'd1; vd = 5'd2;
        rs1_data = 32'h100; result_s = '0; result_v = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", VW'(stall), '0);
        check("rst_mem_req", VW'(mem_req), '0);
        check("rst_mem_we", VW'(mem_we), '0);
        check("rst_mem_addr", VW'(mem_addr), '0);
        check("rst_mem_wdata", VW'(mem_wdata), '0);
        check("rst_wb_s_we", VW'(wb_s_we), '0);
        check("rst_wb_rd", VW'(wb_rd), '0);
        check("rst_wb_s_data", VW'(wb_s_data), '0);
        check("rst_wb_v_we", VW'(wb_v_we), '0);
        check("rst_wb_vd", VW'(wb_vd), '0);
        check("rst_wb_v_data", wb_v_data, '0);
        check("rst_misalign", VW'(misalign), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_bubble();

        // Unit-stride load from 0x100 with word i = i+1 and memory always ready.
        for (int i = 0; i < VL; i++) begin
            ref_mem[32'h100 + 32'(4 * i)] = 32'(i + 1);
            mem_dut[32'h100 + 32'(4 * i)] = 32'(i + 1);
        end
        ready_mode = 0;
        issue(4'd1, 1'b1, 1'b0, 5'd0, 5'd7, 32'h100, 32'h0, '0, nst);
        check("vle_stall_cycles", VW'(nst), VW'(VL));

        // Store to 0x200 with element i = 0xA0+i under a toggling ready.
        for (int i = 0; i < VL; i++) vpat[i*SEW +: SEW] = 32'hA0 + 32'(i);
        ready_mode = 1;
        issue(4'd2, 1'b1, 1'b0, 5'd0, 5'd3, 32'h200, 32'h0, vpat, nst);

        // Scalar writeback.
        ready_mode = 0;
        issue(4'd0, 1'b0, 1'b1, 5'd5, 5'd0, 32'h0, 32'h1234, '0, nst);
        check("addi_stall_cycles", VW'(nst), '0);

        // Misaligned load base: error pulse only.
        issue(4'd1, 1'b1, 1'b1, 5'd0, 5'd9, 32'h102, 32'h0, '0, nst);
        check("misalign_stall_cycles", VW'(nst), '0);

        // Address wraps past the top of the address space.
        issue(4'd1, 1'b1, 1'b0, 5'd0, 5'd4, 32'hFFFF_FFF8, 32'h0, '0, nst);

        // Reset during beat 3 of a load: three beats happen, no writeback.
        sel = 4'd1; data_access = 1'b1; reg_write = 1'b0; vd = 5'd6; rs1_data = 32'h300;
        for (int i = 0; i < 3; i++)
            sb.push_back(make_ev(EV_BEAT, 32'h300 + 32'(4 * i), 1'b0, 0, 0, '0));
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        set_bubble();
        @(negedge clk);
        check("abort_stall_in_rst", VW'(stall), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mem_req", VW'(mem_req), '0);
        check("abort_wb_v_we", VW'(wb_v_we), '0);
        @(posedge clk); #1;
        vpat = rand_vec();
        issue(4'd3, 1'b0, 1'b1, 5'd0, 5'd11, 32'h0, 32'h0, vpat, nst);

        // Randomized instruction stream with random memory back-pressure.
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  s;
            logic        da;
            logic [31:0] base;
            s  = ops[$urandom_range(0, 5)];
            da = (s == 4'd1 || s == 4'd2) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       base = 32'h1000;
                1:       base = 32'h2000;
                2:       base = 32'hFFFF_FFF0;
                default: base = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            endcase
            if ($urandom_range(0, 5) == 0) base[1:0] = 2'($urandom_range(1, 3));
            ready_mode = $urandom_range(0, 2);
            issue(s, da, 1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
                  base, $urandom, rand_vec(), nst);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", VW'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_mem_stage.md
VECTOR_MEM_STAGE -- requirements
Module: vector_mem_stage

Parameters
REQ-001 VL, default 8, elements per vector register.
REQ-002 SEW, default 32, element width in bits; memory bus width equals SEW.

Interface
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 sel  in  4  opcode from execute stage: 0 ADDI, 1 VLE32, 2 VSE32, 3 VADD, 15 bubble.
REQ-006 data_access  in  1  instruction accesses memory.
REQ-007 reg_write  in  1  instruction writes a register.
REQ-008 rd / vd  in  5 each  scalar and vector destination indices.
REQ-009 rs1_data  in  32  vector base byte address.
REQ-010 result_s  in  32  scalar result.
REQ-011 result_v  in  VL*SEW  vector result or store data; element i is bits [SEW*i+SEW-1 : SEW*i].
REQ-012 stall  out  1  hold request to execute stage (combinational).
REQ-013 mem_req / mem_we  out  1 each  memory request and write enable.
REQ-014 mem_addr  out  32  word byte address.
REQ-015 mem_wdata  out  SEW  store beat data.
REQ-016 mem_ready  in  1  beat accept; for reads mem_rdata is valid in the same cycle.
REQ-017 mem_rdata  in  SEW  load beat data.
REQ-018 wb_s_we, wb_rd (5), wb_s_data (32)  out  scalar writeback, registered.
REQ-019 wb_v_we, wb_vd (5), wb_v_data (VL*SEW)  out  vector writeback, registered.
REQ-020 misalign  out  1  registered one-cycle error pulse.

Function
REQ-021 FSM states: IDLE and XFER; a beat counter (0..VL-1) and the latched opcode, vd, base address and store data are held.
REQ-022 In IDLE with sel in {1,2} and data_access=1, the block checks alignment: if rs1_data[1:0]!=0, it pulses misalign next cycle, performs no transfer, issues no writeback, and does not stall.
REQ-023 In IDLE with an aligned vector access, the block asserts stall that cycle, latches the operands, clears the beat counter, and enters XFER.
REQ-024 In XFER, mem_req=1, mem_we=1 for VSE32 and 0 for VLE32, mem_addr=base+4*beat, mem_wdata=latched element[beat].
REQ-025 mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
REQ-026 A beat completes on mem_req&&mem_ready; on a VLE32 beat, mem_rdata is captured into element[beat] of the load buffer.
REQ-027 stall=1 throughout XFER except in the cycle the final beat (beat=VL-1) completes; that cycle stall=0 and the state returns to IDLE.
REQ-028 On completion of a VLE32, the cycle after the final beat carries wb_v_we=1, wb_vd=latched vd and wb_v_data=the assembled buffer; a VSE32 issues no writeback.
REQ-029 In IDLE with sel=0 and reg_write=1, the next cycle carries wb_s_we=1, wb_rd=rd and wb_s_data=result_s.
REQ-030 In IDLE with sel=3 and reg_write=1, the next cycle carries wb_v_we=1, wb_vd=vd and wb_v_data=result_v.
REQ-031 wb_s_we and wb_v_we are single-cycle pulses; sel=15 or any other opcode produces no writeback; inputs are ignored in XFER.
REQ-032 The address adds modulo 2^32; wrap past 0xFFFFFFFC is not an error.

Reset
REQ-033 With rst=1 at a clock edge: state=IDLE, beat=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all wb_* outputs=0, misalign=0.
REQ-034 Reset during XFER aborts the transfer with no writeback; stall=0 while rst=1.

Verification
REQ-035 VLE32 base 0x100, mem_ready=1, memory word at 0x100+4i = i+1 -> mem_req for 8 cycles at addresses 0x100..0x11C; stall high for 8 cycles; wb_v_we one cycle later with element i = i+1.
REQ-036 VSE32 base 0x200 with result_v element i = 0xA0+i, mem_ready toggling 1/0 -> 8 writes with data 0xA0..0xA7 held stable across ready=0 cycles; no writeback.
REQ-037 ADDI rd=5, result_s=0x1234 -> next cycle wb_s_we=1, wb_rd=5, wb_s_data=0x1234; stall stays 0.
REQ-038 VLE32 with base 0x102 -> misalign pulse; no mem_req; no stall.
REQ-039 rst asserted at beat 3 of a VLE32 -> mem_req=0 the next cycle; no wb_v_we; the next VADD writes back normally.
REQ-040 Base 0xFFFFFFF8 load -> beat 2 address is 0x00000000.
